ecc_op_sequencer: RTL

- Sequences the ECC core from the APB-programmed registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and the start strobe.
- Issues one or two core passes per operation: encode, decode, or full channel (encode, then noise injection, then decode).
- Captures the results, flags protocol and timeout errors, and reports completion.
- Sits between the APB register block and the ECC encoder/decoder core.

---
 rtl/ecc_ctrl_pkg.sv | 71 +++++++
 rtl/ecc_wait_timer.sv | 30 +++
 rtl/ecc_op_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC operation sequencer:
// FSM state encoding, CTRL op codes, codeword width codes and k/n masks.
package ecc_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ENC_RUN,
        ST_ENC_WAIT,
        ST_DEC_RUN,
        ST_DEC_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ENC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_FULL = 2'b10,
        OP_BAD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        W8    = 2'b00,
        W16   = 2'b01,
        W32   = 2'b10,
        W_BAD = 2'b11
    } width_t;

    // Payload (k) and codeword (n) sizes for each width code.
    localparam int K_W8  = 4;
    localparam int N_W8  = 8;
    localparam int K_W16 = 11;
    localparam int N_W16 = 16;
    localparam int K_W32 = 26;
    localparam int N_W32 = 32;

    // Mask of the low 'bits' bits; a shift by the full word width yields all ones.
    function automatic logic [WORD_W-1:0] low_mask(input int unsigned bits);
        low_mask = ~({WORD_W{1'b1}} << bits);
    endfunction

    function automatic logic [WORD_W-1:0] kmask(input width_t w);
        case (w)
            W8:      kmask = low_mask(K_W8);
            W16:     kmask = low_mask(K_W16);
            W32:     kmask = low_mask(K_W32);
            default: kmask = '0;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] nmask(input width_t w);
        case (w)
            W8:      nmask = low_mask(N_W8);
            W16:     nmask = low_mask(N_W16);
            W32:     nmask = low_mask(N_W32);
            default: nmask = '0;
        endcase
    endfunction

    function automatic logic op_valid(input op_t op);
        op_valid = (op != OP_BAD);
    endfunction

    function automatic logic width_valid(input width_t w);
        width_valid = (w != W_BAD);
    endfunction

endpackage

// File: rtl/ecc_wait_timer.sv
// Wait-state watchdog: counts cycles while enabled, restarts on clear, and
// flags the cycle in which TIMEOUT_CYCLES cycles have been spent waiting.
module ecc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Cycle counter, saturating at the last wait cycle so it never wraps.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with <= so every register samples pre-edge values.
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign timeout = en && (cnt == LAST);

endmodule

// File: rtl/ecc_op_sequencer.sv
// ECC operation sequencer: turns a start edge plus the programmed registers
// into one (encode/decode) or two (full channel) ECC core passes, masks the
// operands and results to the selected k/n, and reports completion or error.
module ecc_op_sequencer
    import ecc_ctrl_pkg::*;
#(
    parameter int AMBA_WORD      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    input  logic                 core_done,
    input  logic [AMBA_WORD-1:0] core_data_out,
    input  logic [1:0]           core_num_err,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [1:0]           core_width,
    output logic [AMBA_WORD-1:0] core_data,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy,
    output logic                 error_flag
);

    state_t               state;
    op_t                  op_q;
    width_t               width_q;
    logic                 start_q;
    logic [AMBA_WORD-1:0] data_q;
    logic [AMBA_WORD-1:0] noise_q;
    logic [AMBA_WORD-1:0] km;
    logic [AMBA_WORD-1:0] nm;
    logic                 wait_clr;
    logic                 wait_en;
    logic                 timeout;
    logic                 unused_bits;

    assign km         = AMBA_WORD'(kmask(width_q));
    assign nm         = AMBA_WORD'(nmask(width_q));
    assign core_width = width_q;

    // Only the low two bits of CTRL and CODEWORD_WIDTH carry meaning.
    assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // Counter restarts in each RUN state so it reads zero on entry to WAIT.
    assign wait_clr = (state == ST_ENC_RUN) || (state == ST_DEC_RUN);
    assign wait_en  = (state == ST_ENC_WAIT) || (state == ST_DEC_WAIT);

    ecc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .en     (wait_en),
        .timeout(timeout)
    );

    // Sequencer FSM with all core-facing and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand latches are reset as well; they feed outputs that must read 0 after reset.
            state          <= ST_IDLE;
            op_q           <= OP_ENC;
            width_q        <= W8;
            start_q        <= 1'b0;
            data_q         <= '0;
            noise_q        <= '0;
            core_start     <= 1'b0;
            core_mode      <= 1'b0;
            core_data      <= '0;
            data_out       <= '0;
            num_of_errors  <= 2'b00;
            operation_done <= 1'b0;
            busy           <= 1'b0;
            error_flag     <= 1'b0;
        end else begin
            start_q        <= start;
            core_start     <= 1'b0;
            operation_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && !start_q) begin
                        op_q       <= op_t'(CTRL[1:0]);
                        width_q    <= width_t'(CODEWORD_WIDTH[1:0]);
                        data_q     <= DATA_IN;
                        noise_q    <= NOISE;
                        error_flag <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (!op_valid(op_q) || !width_valid(width_q)) begin
                        error_flag     <= 1'b1;
                        data_out       <= '0;
                        num_of_errors  <= 2'b11;
                        operation_done <= 1'b1;
                        state          <= ST_ERR;
                    end else if (op_q == OP_DEC) begin
                        core_start <= 1'b1;
                        core_mode  <= 1'b1;
                        core_data  <= data_q & nm;
                        state      <= ST_DEC_RUN;
                    end else begin
                        core_start <= 1'b1;
                        core_mode  <= 1'b0;
                        core_data  <= data_q & km;
                        state      <= ST_ENC_RUN;
                    end
                end

                ST_ENC_RUN: state <= ST_ENC_WAIT;

                ST_ENC_WAIT: begin
                    if (core_done) begin
                        if (op_q == OP_FULL) begin
                            // core_data doubles as the noisy codeword register for the decode pass.
                            core_start <= 1'b1;
                            core_mode  <= 1'b1;
                            core_data  <= (core_data_out ^ noise_q) & nm;
                            state      <= ST_DEC_RUN;
                        end else begin
                            data_out       <= core_data_out & nm;
                            num_of_errors  <= 2'b00;
                            operation_done <= 1'b1;
                            state          <= ST_DONE;
                        end
                    end else if (timeout) begin
                        error_flag     <= 1'b1;
                        data_out       <= '0;
                        num_of_errors  <= 2'b11;
                        operation_done <= 1'b1;
                        state          <= ST_ERR;
                    end
                end

                ST_DEC_RUN: state <= ST_DEC_WAIT;

                ST_DEC_WAIT: begin
                    if (core_done) begin
                        data_out       <= core_data_out & km;
                        num_of_errors  <= core_num_err;
                        operation_done <= 1'b1;
                        state          <= ST_DONE;
                    end else if (timeout) begin
                        error_flag     <= 1'b1;
                        data_out       <= '0;
                        num_of_errors  <= 2'b11;
                        operation_done <= 1'b1;
                        state          <= ST_ERR;
                    end
                end

                ST_DONE, ST_ERR: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
